// File: rtl/tlb_port_arbiter_if.sv
// Pipeline-side and tlb-side signals of the TLB port arbiter.
// slave = arbiter view, master = surrounding pipeline/tlb view.
interface tlb_port_arbiter_if #(
    parameter int unsigned IDXW = 4
);
    localparam int unsigned VPNW = 19;
    localparam int unsigned PFNW = 20;
    localparam int unsigned CDVW = 5;
    localparam int unsigned ASIDW = 8;

    logic             if_req;
    logic [VPNW-1:0]  if_vpn2;
    logic             if_odd;
    logic             if_grant;
    logic             mem_req;
    logic [VPNW-1:0]  mem_vpn2;
    logic             mem_odd;
    logic             mem_grant;
    logic [ASIDW-1:0] asid;
    logic             res_valid;
    logic             res_owner;
    logic             res_found;
    logic [PFNW-1:0]  res_pfn;
    logic [CDVW-1:0]  res_cdv;
    logic             cancel;
    logic             op_valid;
    logic [1:0]       op_type;
    logic [VPNW-1:0]  op_vpn2;
    logic             op_ready;
    logic             op_done;
    logic             op_found;
    logic [IDXW-1:0]  op_index;
    logic             refetch_req;
    logic [VPNW-1:0]  s_vpn2;
    logic             s_odd;
    logic [ASIDW-1:0] s_asid;
    logic             s_found;
    logic [IDXW-1:0]  s_index;
    logic [PFNW-1:0]  s_pfn;
    logic [CDVW-1:0]  s_cdv;
    logic             tlb_we;
    logic             tlbr_en;

    modport slave (
        input  if_req, if_vpn2, if_odd, mem_req, mem_vpn2, mem_odd, asid, cancel,
        input  op_valid, op_type, op_vpn2, s_found, s_index, s_pfn, s_cdv,
        output if_grant, mem_grant, res_valid, res_owner, res_found, res_pfn, res_cdv,
        output op_ready, op_done, op_found, op_index, refetch_req,
        output s_vpn2, s_odd, s_asid, tlb_we, tlbr_en
    );

    modport master (
        output if_req, if_vpn2, if_odd, mem_req, mem_vpn2, mem_odd, asid, cancel,
        output op_valid, op_type, op_vpn2, s_found, s_index, s_pfn, s_cdv,
        input  if_grant, mem_grant, res_valid, res_owner, res_found, res_pfn, res_cdv,
        input  op_ready, op_done, op_found, op_index, refetch_req,
        input  s_vpn2, s_odd, s_asid, tlb_we, tlbr_en
    );
endinterface

// File: rtl/tlb_port_arbiter.sv
// Serialises IF/MEM lookups and CP0 maintenance ops onto the single TLB search port,
// keeping searches away from a TLBWI until the write is visible.
module tlb_port_arbiter #(
    parameter int unsigned TLBNUM     = 16,
    parameter int unsigned IDXW       = $clog2(TLBNUM),
    parameter int unsigned STARVE_MAX = 4
) (
    input logic               clk,
    input logic               reset,
    tlb_port_arbiter_if.slave bus
);
    localparam int unsigned VPNW  = 19;
    localparam int unsigned PFNW  = 20;
    localparam int unsigned CDVW  = 5;
    localparam int unsigned ASIDW = 8;
    localparam int unsigned CNTW  = $clog2(STARVE_MAX + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] OP_P     = 3'd1;
    localparam logic [2:0] OP_R     = 3'd2;
    localparam logic [2:0] OP_W     = 3'd3;
    localparam logic [2:0] OP_FLUSH = 3'd4;

    localparam logic [1:0] T_NOP   = 2'b00;
    localparam logic [1:0] T_TLBP  = 2'b01;
    localparam logic [1:0] T_TLBR  = 2'b10;
    localparam logic [1:0] T_TLBWI = 2'b11;

    logic [2:0]       state, next_state;
    logic [CNTW-1:0]  starve_cnt;
    logic             if_grant_c, mem_grant_c, op_ready_c;
    logic [VPNW-1:0]  s_vpn2_c;
    logic             s_odd_c;
    logic [ASIDW-1:0] s_asid_c;
    logic [VPNW-1:0]  op_vpn2_q;

    logic             res_valid_q, res_owner_q, res_found_q;
    logic [PFNW-1:0]  res_pfn_q;
    logic [CDVW-1:0]  res_cdv_q;
    logic             op_done_q, op_found_q, refetch_q, tlb_we_q, tlbr_en_q;
    logic [IDXW-1:0]  op_index_q;
    logic             if_starved;

    assign if_starved = bus.if_req && (starve_cnt == CNTW'(STARVE_MAX));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state, arbitration and search-port steering
    always_comb begin
        next_state  = state;
        if_grant_c  = 1'b0;
        mem_grant_c = 1'b0;
        op_ready_c  = 1'b0;
        s_vpn2_c    = '0;
        s_odd_c     = 1'b0;
        s_asid_c    = '0;
        case (state)
            IDLE: begin
                if (bus.op_valid) begin
                    op_ready_c = 1'b1;
                    case (bus.op_type)
                        T_TLBP:  next_state = OP_P;
                        T_TLBR:  next_state = OP_R;
                        T_TLBWI: next_state = OP_W;
                        default: next_state = IDLE;
                    endcase
                end else if (bus.mem_req && !if_starved) begin
                    mem_grant_c = 1'b1;
                    s_vpn2_c    = bus.mem_vpn2;
                    s_odd_c     = bus.mem_odd;
                    s_asid_c    = bus.asid;
                end else if (bus.if_req) begin
                    if_grant_c = 1'b1;
                    s_vpn2_c   = bus.if_vpn2;
                    s_odd_c    = bus.if_odd;
                    s_asid_c   = bus.asid;
                end
            end
            OP_P: begin
                s_vpn2_c   = op_vpn2_q;
                s_asid_c   = bus.asid;
                next_state = IDLE;
            end
            OP_R:     next_state = IDLE;
            OP_W:     next_state = OP_FLUSH;
            OP_FLUSH: next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // IF starvation counter, saturating at STARVE_MAX
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (bus.if_req && !if_grant_c) begin
            if (starve_cnt != CNTW'(STARVE_MAX)) starve_cnt <= starve_cnt + CNTW'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Lookup result capture at the grant edge
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_owner_q <= 1'b0;
            res_found_q <= 1'b0;
            res_pfn_q   <= '0;
            res_cdv_q   <= '0;
        end else begin
            res_valid_q <= (if_grant_c || mem_grant_c) && !bus.cancel;
            if (if_grant_c || mem_grant_c) begin
                res_owner_q <= mem_grant_c;
                res_found_q <= bus.s_found;
                res_pfn_q   <= bus.s_pfn;
                res_cdv_q   <= bus.s_cdv;
            end
        end
    end

    // Maintenance-op strobes and TLBP result; strobes land one cycle after their trigger
    always_ff @(posedge clk) begin
        if (reset) begin
            op_vpn2_q  <= '0;
            op_done_q  <= 1'b0;
            op_found_q <= 1'b0;
            op_index_q <= '0;
            refetch_q  <= 1'b0;
            tlb_we_q   <= 1'b0;
            tlbr_en_q  <= 1'b0;
        end else begin
            if (op_ready_c) op_vpn2_q <= bus.op_vpn2;
            op_done_q <= (state == OP_P) || (state == OP_R) || (state == OP_W) ||
                         (op_ready_c && (bus.op_type == T_NOP));
            refetch_q <= (state == OP_W);
            tlb_we_q  <= op_ready_c && (bus.op_type == T_TLBWI);
            tlbr_en_q <= op_ready_c && (bus.op_type == T_TLBR);
            if (state == OP_P) begin
                op_found_q <= bus.s_found;
                op_index_q <= bus.s_index;
            end
        end
    end

    assign bus.if_grant    = if_grant_c;
    assign bus.mem_grant   = mem_grant_c;
    assign bus.op_ready    = op_ready_c;
    assign bus.s_vpn2      = s_vpn2_c;
    assign bus.s_odd       = s_odd_c;
    assign bus.s_asid      = s_asid_c;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_owner   = res_owner_q;
    assign bus.res_found   = res_found_q;
    assign bus.res_pfn     = res_pfn_q;
    assign bus.res_cdv     = res_cdv_q;
    assign bus.op_done     = op_done_q;
    assign bus.op_found    = op_found_q;
    assign bus.op_index    = op_index_q;
    assign bus.refetch_req = refetch_q;
    assign bus.tlb_we      = tlb_we_q;
    assign bus.tlbr_en     = tlbr_en_q;
endmodule

// File: tb/tb_tlb_port_arbiter.sv
// Directed bench for tlb_port_arbiter with a two-entry combinational TLB search model.
module tb_tlb_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int unsigned errors = 0;
    int unsigned checks = 0;

    tlb_port_arbiter_if #(.IDXW(4)) bus();

    tlb_port_arbiter #(.TLBNUM(16), .IDXW(4), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // TLB model: entry 7 = vpn2 00010 (even pfn 00123), entry 3 = vpn2 00abc (even pfn 00777)
    always_comb begin
        bus.s_found = 1'b0;
        bus.s_index = 4'd0;
        bus.s_pfn   = 20'h0;
        bus.s_cdv   = 5'h0;
        if (bus.s_vpn2 == 19'h00010 && bus.s_asid == 8'h05) begin
            bus.s_found = 1'b1;
            bus.s_index = 4'd7;
            bus.s_pfn   = bus.s_odd ? 20'h00456 : 20'h00123;
            bus.s_cdv   = 5'h1b;
        end else if (bus.s_vpn2 == 19'h00abc && bus.s_asid == 8'h05) begin
            bus.s_found = 1'b1;
            bus.s_index = 4'd3;
            bus.s_pfn   = bus.s_odd ? 20'h00888 : 20'h00777;
            bus.s_cdv   = 5'h07;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_vpn2  = '0;
        bus.if_odd   = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_vpn2 = '0;
        bus.mem_odd  = 1'b0;
        bus.asid     = 8'h05;
        bus.cancel   = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_type  = 2'b00;
        bus.op_vpn2  = '0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_op_done", 32'(bus.op_done), 0);
        chk("rst_tlb_we", 32'(bus.tlb_we), 0);
        chk("rst_refetch", 32'(bus.refetch_req), 0);
        chk("rst_grants", 32'({bus.if_grant, bus.mem_grant, bus.op_ready}), 0);
        chk("rst_s_vpn2", 32'(bus.s_vpn2), 0);

        // IF alone
        step(); bus.if_req = 1'b1; bus.if_vpn2 = 19'h00010; #1;
        chk("if_alone_grant", 32'(bus.if_grant), 1);
        chk("if_alone_s_vpn2", 32'(bus.s_vpn2), 32'h00010);
        step(); bus.if_req = 1'b0; #1;
        chk("if_alone_res_valid", 32'(bus.res_valid), 1);
        chk("if_alone_owner", 32'(bus.res_owner), 0);
        chk("if_alone_pfn", 32'(bus.res_pfn), 32'h00123);
        chk("if_alone_cdv", 32'(bus.res_cdv), 32'h1b);

        // Contention: MEM wins 4 cycles, IF forced in cycle 4, MEM again in 5
        bus.mem_vpn2 = 19'h00abc;
        for (int k = 0; k < 6; k++) begin
            step(); bus.if_req = 1'b1; bus.mem_req = 1'b1; #1;
            chk($sformatf("cont_if_grant_c%0d", k), 32'(bus.if_grant), (k == 4) ? 1 : 0);
            chk($sformatf("cont_mem_grant_c%0d", k), 32'(bus.mem_grant), (k == 4) ? 0 : 1);
            if (k == 5) begin
                chk("cont_owner_if", 32'(bus.res_owner), 0);
                chk("cont_pfn_if", 32'(bus.res_pfn), 32'h00123);
            end
        end
        step(); bus.if_req = 1'b0; bus.mem_req = 1'b0; #1;
        chk("cont_owner_mem", 32'(bus.res_owner), 1);
        chk("cont_pfn_mem", 32'(bus.res_pfn), 32'h00777);

        // TLBP hit at entry 7
        step(); bus.op_valid = 1'b1; bus.op_type = 2'b01; bus.op_vpn2 = 19'h00010; #1;
        chk("tlbp_ready", 32'(bus.op_ready), 1);
        step(); bus.op_valid = 1'b0; #1;
        chk("tlbp_busy_ready", 32'(bus.op_ready), 0);
        chk("tlbp_s_vpn2", 32'(bus.s_vpn2), 32'h00010);
        chk("tlbp_done_early", 32'(bus.op_done), 0);
        step(); #1;
        chk("tlbp_done", 32'(bus.op_done), 1);
        chk("tlbp_found", 32'(bus.op_found), 1);
        chk("tlbp_index", 32'(bus.op_index), 7);

        // TLBP miss
        step(); bus.op_valid = 1'b1; bus.op_vpn2 = 19'h12345; #1;
        chk("tlbp_done_pulse", 32'(bus.op_done), 0);
        chk("tlbp_miss_ready", 32'(bus.op_ready), 1);
        step(); bus.op_valid = 1'b0; #1;
        step(); #1;
        chk("tlbp_miss_done", 32'(bus.op_done), 1);
        chk("tlbp_miss_found", 32'(bus.op_found), 0);

        // TLBR
        step(); bus.op_valid = 1'b1; bus.op_type = 2'b10; #1;
        chk("tlbr_ready", 32'(bus.op_ready), 1);
        step(); bus.op_valid = 1'b0; #1;
        chk("tlbr_en", 32'(bus.tlbr_en), 1);
        step(); #1;
        chk("tlbr_done", 32'(bus.op_done), 1);
        chk("tlbr_en_off", 32'(bus.tlbr_en), 0);

        // TLBWI with MEM requesting throughout
        step(); bus.op_valid = 1'b1; bus.op_type = 2'b11; bus.mem_req = 1'b1; #1;
        chk("tlbwi_ready", 32'(bus.op_ready), 1);
        chk("tlbwi_c0_mem_grant", 32'(bus.mem_grant), 0);
        chk("tlbwi_c0_we", 32'(bus.tlb_we), 0);
        step(); bus.op_valid = 1'b0; #1;
        chk("tlbwi_c1_we", 32'(bus.tlb_we), 1);
        chk("tlbwi_c1_mem_grant", 32'(bus.mem_grant), 0);
        chk("tlbwi_c1_refetch", 32'(bus.refetch_req), 0);
        step(); #1;
        chk("tlbwi_c2_we", 32'(bus.tlb_we), 0);
        chk("tlbwi_c2_refetch", 32'(bus.refetch_req), 1);
        chk("tlbwi_c2_done", 32'(bus.op_done), 1);
        chk("tlbwi_c2_mem_grant", 32'(bus.mem_grant), 0);
        step(); #1;
        chk("tlbwi_c3_mem_grant", 32'(bus.mem_grant), 1);
        chk("tlbwi_c3_refetch", 32'(bus.refetch_req), 0);

        // Cancel in grant cycle suppresses res_valid
        step(); bus.cancel = 1'b1; #1;
        chk("cancel_prev_valid", 32'(bus.res_valid), 1);
        chk("cancel_grant", 32'(bus.mem_grant), 1);
        step(); bus.cancel = 1'b0; bus.mem_req = 1'b0; #1;
        chk("cancel_res_valid", 32'(bus.res_valid), 0);

        // op_type 00: accepted, done next cycle, stays idle
        step(); bus.op_valid = 1'b1; bus.op_type = 2'b00; #1;
        chk("nop_ready", 32'(bus.op_ready), 1);
        step(); bus.op_valid = 1'b0; bus.if_req = 1'b1; bus.if_vpn2 = 19'h00010; #1;
        chk("nop_done", 32'(bus.op_done), 1);
        chk("nop_idle_if_grant", 32'(bus.if_grant), 1);
        chk("nop_tlb_we", 32'(bus.tlb_we), 0);

        // Reset asserted during OP_W
        step(); bus.if_req = 1'b0; bus.op_valid = 1'b1; bus.op_type = 2'b11; #1;
        chk("rstw_ready", 32'(bus.op_ready), 1);
        step(); bus.op_valid = 1'b0; reset = 1'b1; #1;
        chk("rstw_we_c1", 32'(bus.tlb_we), 1);
        step(); reset = 1'b0; bus.mem_req = 1'b1; #1;
        chk("rstw_we_c2", 32'(bus.tlb_we), 0);
        chk("rstw_refetch_c2", 32'(bus.refetch_req), 0);
        chk("rstw_done_c2", 32'(bus.op_done), 0);
        chk("rstw_idle_mem_grant", 32'(bus.mem_grant), 1);
        step(); bus.mem_req = 1'b0; #1;
        chk("rstw_refetch_c3", 32'(bus.refetch_req), 0);
        chk("rstw_done_c3", 32'(bus.op_done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tlb_port_arbiter.md
Name: tlb_port_arbiter

Overview:
- Owns the TLB's single search port and its read/write ports, and serialises every access to them.
- Shares the search port between instruction-fetch lookups (IF), data lookups (MEM) and CP0 maintenance ops (TLBP/TLBR/TLBWI) issued by the writeback stage.
- Guarantees that a TLBWI is never overlapped by a search, and raises a refetch request once the write is visible.
- Sits between the pipeline stages and the tlb module; CP0 consumes its op results.

Parameters:
- TLBNUM, 16, number of TLB entries.
- IDXW, 4, index width (log2 TLBNUM).
- STARVE_MAX, 4, consecutive cycles IF may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF lookup request
- if_vpn2  in  19  IF virtual page number/2
- if_odd  in  1  IF odd-page select
- if_grant  out  1  IF request accepted this cycle
- mem_req  in  1  MEM lookup request
- mem_vpn2  in  19  MEM vpn2
- mem_odd  in  1  MEM odd-page select
- mem_grant  out  1  MEM request accepted this cycle
- asid  in  8  current EntryHi.ASID
- res_valid  out  1  lookup result valid (one cycle after grant)
- res_owner  out  1  0 = IF, 1 = MEM
- res_found  out  1  registered s_found
- res_pfn  out  20  registered s_pfn
- res_cdv  out  5  registered {c[2:0], d, v}
- cancel  in  1  pipeline flush; suppresses res_valid next cycle
- op_valid  in  1  maintenance op request from WB
- op_type  in  2  01 TLBP, 10 TLBR, 11 TLBWI
- op_vpn2  in  19  EntryHi.VPN2 for TLBP
- op_ready  out  1  op accepted
- op_done  out  1  one-cycle completion pulse
- op_found  out  1  TLBP hit
- op_index  out  IDXW  TLBP matching index
- refetch_req  out  1  one-cycle pulse after TLBWI
- s_vpn2  out  19  to tlb search port
- s_odd  out  1  to tlb search port
- s_asid  out  8  to tlb search port
- s_found  in  1  from tlb search port
- s_index  in  IDXW  from tlb search port
- s_pfn  in  20  from tlb search port
- s_cdv  in  5  from tlb search port
- tlb_we  out  1  tlb write enable
- tlbr_en  out  1  CP0 capture strobe for tlb read port data

Behaviour:
- Reset: state IDLE; all outputs 0; starvation counter 0.
- FSM states:
  - IDLE: search port is granted combinationally.
  - OP_P, OP_R, OP_W, OP_FLUSH: maintenance in progress.
- IDLE arbitration, per cycle, at most one grant:
  - MEM beats IF unless the starvation counter equals STARVE_MAX; then IF wins.
  - Granted requester's vpn2/odd and the asid input drive s_*. With no grant, s_* = 0.
- Result timing:
  - s_found/pfn/cdv and owner are registered at the grant edge.
  - res_valid=1 in the next cycle unless cancel was high in the grant cycle.
  - Throughput: one lookup per cycle.
- Starvation counter:
  - Increments when if_req=1 and IF is not granted, saturating at STARVE_MAX.
  - Clears on if_grant or when if_req=0.
- op_valid in IDLE:
  - op_ready=1 and no search grant that cycle (op has priority over IF and MEM).
  - Next state by op_type: 01 → OP_P, 10 → OP_R, 11 → OP_W.
  - op_type=00 is accepted and op_done pulses next cycle with no action.
- OP_P (1 cycle):
  - s_vpn2=op_vpn2, s_asid=asid, s_odd=0.
  - Capture op_found=s_found and op_index=s_index; op_done=1 next cycle; → IDLE.
  - op_found/op_index hold until the next TLBP completes.
- OP_R (1 cycle): tlbr_en=1; → IDLE with op_done=1.
- OP_W:
  - tlb_we=1 for exactly one cycle; no grants.
  - → OP_FLUSH: one idle cycle so the write is visible, no grants; refetch_req=1 and op_done=1 this cycle; → IDLE.
- Grant blocking: if_grant/mem_grant are 0 in every non-IDLE state; requesters hold req.
- Only one op is accepted per IDLE entry; op_ready=0 outside IDLE.
- Reset mid-op: the FSM returns to IDLE; no op_done, no refetch_req.
- Cancel has no effect on maintenance ops.

Test Plan:
- IF alone: if_req=1, if_vpn2=19'h00010, tlb entry hit pfn=20'h00123 → if_grant same cycle; next cycle res_valid=1, res_owner=0, res_pfn=20'h00123.
- Contention: if_req=mem_req=1 for 6 cycles →
  - mem_grant in cycles 0–3 (IF loses 4 consecutive cycles, counter reaches STARVE_MAX=4).
  - if_grant in cycle 4, counter clears.
  - mem_grant in cycle 5.
- TLBP hit at entry 7: op_valid, op_type=01, op_vpn2 matching → op_ready cycle 0, op_done cycle 2, op_found=1, op_index=4'd7. Miss variant → op_found=0.
- TLBWI with concurrent mem_req=1:
  - tlb_we=1 exactly in cycle 1.
  - refetch_req and op_done in cycle 2.
  - No mem_grant in cycles 0–2; mem_grant in cycle 3.
- Cancel: mem grant in cycle 0 with cancel=1 → res_valid=0 in cycle 1.
- Reset asserted in OP_W → next cycle IDLE, tlb_we=0, no refetch_req, no op_done.
